// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : Instruction fetch unit with in-order fetch queue and redirect flush.
//            Optional macro FETCH_PERF_CNT_EN adds the stall_cycles counter.
// Revision : 1.0
// ============================================================================
module instr_fetch #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cycles
`endif
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    logic [XLEN-1:0]    entry_pc_q    [DEPTH];
    logic [31:0]        entry_instr_q [DEPTH];
    logic [DEPTH-1:0]   filled_q;
    logic [c_ptr_w-1:0] head_q, head_d;
    logic [c_ptr_w-1:0] tail_q, tail_d;
    logic [c_ptr_w-1:0] fill_q, fill_d;
    logic [c_cnt_w-1:0] alloc_cnt_q, alloc_cnt_d;
    logic [c_cnt_w-1:0] pend_cnt_q, pend_cnt_d;
    logic [c_cnt_w-1:0] drop_cnt_q, drop_cnt_d;

    logic               w_redirect;
    logic               w_issue;
    logic               w_pop;
    logic               w_resp_drop;
    logic               w_resp_fill;
    logic [c_cnt_w:0]   w_occupancy;

    assign w_redirect  = redirect_valid & ~reset;
    assign w_occupancy = {1'b0, alloc_cnt_q} + {1'b0, drop_cnt_q};

    assign imem_req_addr  = pc;
    assign imem_req_valid = ~reset & ~redirect_valid & (w_occupancy < (c_cnt_w+1)'(DEPTH));
    assign w_issue        = imem_req_valid & imem_req_ready;
    assign w_pop          = id_valid & id_ready & ~w_redirect;

    // Stale responses are consumed first; a response with nothing outstanding is ignored.
    assign w_resp_drop = imem_resp_valid & (drop_cnt_q != '0);
    assign w_resp_fill = imem_resp_valid & (drop_cnt_q == '0) & (pend_cnt_q != '0);

    assign pc_next = w_redirect ? redirect_pc :
                     w_issue    ? pc + XLEN'(4) : pc;

    assign id_valid = filled_q[head_q];
    assign id_pc    = entry_pc_q[head_q];
    assign id_instr = entry_instr_q[head_q];

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        fill_d      = fill_q;
        alloc_cnt_d = alloc_cnt_q;
        pend_cnt_d  = pend_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (w_redirect) begin
            head_d      = '0;
            tail_d      = '0;
            fill_d      = '0;
            alloc_cnt_d = '0;
            pend_cnt_d  = '0;
            // A response arriving with the redirect already pays off one stale request.
            drop_cnt_d  = drop_cnt_q + pend_cnt_q - c_cnt_w'(w_resp_drop | w_resp_fill);
        end else begin
            if (w_issue) begin
                tail_d = tail_q + c_ptr_one;
            end
            if (w_resp_fill) begin
                fill_d = fill_q + c_ptr_one;
            end
            if (w_pop) begin
                head_d = head_q + c_ptr_one;
            end
            alloc_cnt_d = alloc_cnt_q + c_cnt_w'(w_issue) - c_cnt_w'(w_pop);
            pend_cnt_d  = pend_cnt_q + c_cnt_w'(w_issue) - c_cnt_w'(w_resp_fill);
            drop_cnt_d  = drop_cnt_q - c_cnt_w'(w_resp_drop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            fill_q      <= '0;
            alloc_cnt_q <= '0;
            pend_cnt_q  <= '0;
            drop_cnt_q  <= '0;
            filled_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_pc_q[i]    <= '0;
                entry_instr_q[i] <= '0;
            end
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            fill_q      <= fill_d;
            alloc_cnt_q <= alloc_cnt_d;
            pend_cnt_q  <= pend_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            if (w_redirect) begin
                filled_q <= '0;
            end else begin
                if (w_issue) begin
                    entry_pc_q[tail_q] <= pc;
                end
                if (w_resp_fill) begin
                    entry_instr_q[fill_q] <= imem_resp_data;
                    filled_q[fill_q]      <= 1'b1;
                end
                if (w_pop) begin
                    filled_q[head_q] <= 1'b0;
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (!id_valid && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Directed self-checking bench for instr_fetch with in-order memory model.
// Revision : 1.0
// ============================================================================
module tb_instr_fetch;

    localparam int DEPTH = 4;
    localparam int XLEN  = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [31:0]     id_instr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]     stall_cycles;
`endif

    int              total = 0;
    int              bad = 0;
    int              cyc = 0;
    int              n_issue = 0;
    logic            mem_stall;
    logic [XLEN-1:0] memq_addr [$];
    int              memq_due [$];
    logic [95:0]     expq [$];

    instr_fetch #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc              (pc),
        .pc_next         (pc_next),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_pc           (id_pc),
        .id_instr        (id_instr)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles    (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mdata(input logic [XLEN-1:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: score pops, record issues, advance the PC register, drive memory.
    task automatic tick();
        logic [XLEN-1:0] nx;
        logic [95:0]     e;
        #1;
        if (reset) begin
            memq_addr.delete();
            memq_due.delete();
            expq.delete();
        end else begin
            if (id_valid && id_ready && !redirect_valid) begin
                chk("scoreboard_nonempty", 64'(expq.size() > 0), 64'd1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk("sb_id_pc", id_pc, e[95:32]);
                    chk("sb_id_instr", {32'd0, id_instr}, {32'd0, e[31:0]});
                end
            end
            if (redirect_valid) begin
                expq.delete();
            end
            if (imem_req_valid && imem_req_ready) begin
                memq_addr.push_back(imem_req_addr);
                memq_due.push_back(cyc + 1);
                expq.push_back({imem_req_addr, mdata(imem_req_addr)});
                n_issue++;
            end
        end
        nx = pc_next;
        @(posedge clk);
        #1;
        pc = nx;
        cyc++;
        if (!reset && memq_addr.size() > 0 && memq_due[0] <= cyc && !mem_stall) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mdata(memq_addr.pop_front());
            void'(memq_due.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'd0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; pc = '0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        id_ready = 1'b0; mem_stall = 1'b0;
        repeat (2) tick();
        #1;
        chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("rst_id_valid", {63'd0, id_valid}, 64'd0);
        chk("rst_pc_next", pc_next, 64'h0);
        redirect_valid = 1'b1; redirect_pc = 64'h500;
        #1;
        chk("rst_redirect_pc_next", pc_next, 64'h0);
        redirect_valid = 1'b0;

        // Spurious response with nothing outstanding
        reset = 1'b0;
        #1;
        chk("spur_req_valid", {63'd0, imem_req_valid}, 64'd1);
        imem_resp_valid = 1'b1; imem_resp_data = 32'hDEADBEEF;
        tick();
        #1;
        chk("spur_ignored", {63'd0, id_valid}, 64'd0);
        chk("spur_pc_hold", pc_next, 64'h0);

        // Streaming with one-cycle memory
        imem_req_ready = 1'b1; id_ready = 1'b1;
        #1;
        chk("s1_addr0", imem_req_addr, 64'h0);
        tick();
        #1;
        chk("s1_addr1", imem_req_addr, 64'h4);
        chk("s1_no_early_valid", {63'd0, id_valid}, 64'd0);
        tick();
        #1;
        chk("s1_id_valid", {63'd0, id_valid}, 64'd1);
        chk("s1_id_pc", id_pc, 64'h0);
        chk("s1_id_instr", {32'd0, id_instr}, {32'd0, mdata(64'h0)});
        chk("s1_addr2", imem_req_addr, 64'h8);
        repeat (8) tick();

        // Fill to DEPTH with decode stalled
        reset = 1'b1;
        tick();
        pc = 64'h200; reset = 1'b0; id_ready = 1'b0; n_issue = 0;
        repeat (10) tick();
        #1;
        chk("s2_issue_count", 64'(n_issue), 64'd4);
        chk("s2_req_blocked", {63'd0, imem_req_valid}, 64'd0);
        chk("s2_pc_hold", pc_next, 64'h210);
        id_ready = 1'b1;
        #1;
        chk("s2_head_pc", id_pc, 64'h200);
        tick();
        id_ready = 1'b0; mem_stall = 1'b1;
        #1;
        chk("s2_reenable", {63'd0, imem_req_valid}, 64'd1);
        tick();

        // Response and pop in the same cycle while full
        #1;
        chk("s3_full", {63'd0, imem_req_valid}, 64'd0);
        mem_stall = 1'b0;
        tick();
        id_ready = 1'b1;
        #1;
        chk("s3_resp_present", {63'd0, imem_resp_valid}, 64'd1);
        chk("s3_head_pc", id_pc, 64'h204);
        tick();
        #1;
        chk("s3_after_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("s3_after_head_pc", id_pc, 64'h208);
        repeat (8) tick();

        // Redirect with two requests outstanding
        reset = 1'b1;
        tick();
        pc = 64'h300; reset = 1'b0; mem_stall = 1'b1; id_ready = 1'b1;
        tick();
        mem_stall = 1'b0;
        tick();
        redirect_valid = 1'b1; redirect_pc = 64'h100; id_ready = 1'b0;
        #1;
        chk("s4_pc_next", pc_next, 64'h100);
        chk("s4_req_valid", {63'd0, imem_req_valid}, 64'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("s4_addr", imem_req_addr, 64'h100);
        for (int i = 0; i < 10 && !id_valid; i++) tick();
        #1;
        chk("s4_id_valid", {63'd0, id_valid}, 64'd1);
        chk("s4_id_pc", id_pc, 64'h100);
        chk("s4_id_instr", {32'd0, id_instr}, {32'd0, mdata(64'h100)});
        id_ready = 1'b1;
        repeat (8) tick();

        // Asynchronous reset mid-stream
        id_ready = 1'b0;
        repeat (3) tick();
        #1;
        chk("s5_pre_valid", {63'd0, id_valid}, 64'd1);
        reset = 1'b1;
        #1;
        chk("s5_async_id_valid", {63'd0, id_valid}, 64'd0);
        chk("s5_async_req_valid", {63'd0, imem_req_valid}, 64'd0);
        pc = 64'h400;
        tick();
        reset = 1'b0; id_ready = 1'b1;
        #1;
        chk("s5_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("s5_addr", imem_req_addr, 64'h400);
        tick();
        tick();
        #1;
        chk("s5_id_valid", {63'd0, id_valid}, 64'd1);
        chk("s5_id_pc", id_pc, 64'h400);
        repeat (6) tick();

`ifdef FETCH_PERF_CNT_EN
        reset = 1'b1;
        tick();
        reset = 1'b0; mem_stall = 1'b1;
        repeat (10) tick();
        #1;
        chk("perf_stall_cycles", {32'd0, stall_cycles}, 64'd10);
        mem_stall = 1'b0;
        repeat (6) tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: DEPTH, 4, fetch queue entries (power of two, 2..16).
REQ-002 Parameter: XLEN, 64, PC/address width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pc  input  XLEN  current PC, driven by the PC register output.
REQ-006 pc_next  output  XLEN  next PC, drives the PC register's input.
REQ-007 redirect_valid  input  1  branch/jump redirect; flushes fetch.
REQ-008 redirect_pc  input  XLEN  redirect target.
REQ-009 imem_req_valid  output  1  instruction-memory request valid.
REQ-010 imem_req_ready  input  1  memory accepts request.
REQ-011 imem_req_addr  output  XLEN  request address.
REQ-012 imem_resp_valid  input  1  response valid; responses return in request order.
REQ-013 imem_resp_data  input  32  fetched instruction.
REQ-014 id_valid  output  1  decode-side entry available.
REQ-015 id_ready  input  1  decode accepts entry.
REQ-016 id_pc  output  XLEN  PC of head entry.
REQ-017 id_instr  output  32  instruction of head entry.
REQ-018 stall_cycles  output  32  present only under FETCH_PERF_CNT_EN.

Function
REQ-019 issue = imem_req_valid & imem_req_ready; pop = id_valid & id_ready.
REQ-020 imem_req_addr SHALL equal pc combinationally.
REQ-021 imem_req_valid SHALL be 1 iff !reset & !redirect_valid & (alloc_cnt + drop_cnt) < DEPTH, using registered counts only (no id_ready lookahead).
REQ-022 pc_next SHALL be redirect_pc if redirect_valid, else pc+4 (mod 2^XLEN) if issue, else pc.
REQ-023 On issue, SHALL allocate tail entry {pc, filled=0}; alloc_cnt increments.
REQ-024 Non-dropped response SHALL write imem_resp_data into oldest unfilled entry and set filled.
REQ-025 id_valid SHALL equal head entry filled; id_pc/id_instr driven from head entry registers.
REQ-026 On pop, head SHALL advance and alloc_cnt decrement; pop and issue same cycle: net count unchanged.
REQ-027 Response on cycle N SHALL give id_valid no earlier than N+1; a response landing in the empty head entry gives id_valid exactly at N+1.
REQ-028 On redirect_valid: all entries invalidated, pointers reset, drop_cnt += (requested-but-unanswered count), pop ignored that cycle; effective next cycle.
REQ-029 Responses while drop_cnt>0 (including one coincident with redirect) SHALL be discarded, decrementing drop_cnt.
REQ-030 imem_resp_valid with no outstanding request and drop_cnt=0 SHALL be ignored.
REQ-031 Pointers SHALL wrap modulo DEPTH; alloc_cnt never exceeds DEPTH.

Reset
REQ-032 While reset high: entries invalid, pointers, alloc_cnt, drop_cnt zero; id_valid=0; imem_req_valid=0; pc_next=pc.
REQ-033 Reset mid-operation SHALL abandon outstanding requests without drop tracking; memory is reset by the same signal.
REQ-034 stall_cycles SHALL reset to 0.

Configuration
REQ-035 Macro FETCH_PERF_CNT_EN: defined -> stall_cycles port exists, increments (saturating at 2^32-1) each cycle id_valid=0 and reset low.
REQ-036 Not defined -> port and counter absent; all other behaviour identical.

Verification
REQ-037 Reset release, pc=0x0, ready=1, 1-cycle memory -> addrs 0x0,0x4,0x8 issued; id_pc=0x0 id_instr=first data one cycle after response.
REQ-038 id_ready=0, DEPTH=4 -> exactly 4 issues then imem_req_valid=0; pc_next holds; one pop re-enables request next cycle.
REQ-039 2 requests outstanding, redirect_valid with redirect_pc=0x100 -> pc_next=0x100, next 2 responses discarded, next id_pc=0x100.
REQ-040 Response and pop same cycle with queue full -> occupancy unchanged, data order preserved.
REQ-041 Reset asserted mid-stream -> id_valid and imem_req_valid 0 immediately (asynchronously); fresh fetch from pc after release.
REQ-042 FETCH_PERF_CNT_EN defined, memory stalled 10 cycles after reset -> stall_cycles=10.
